serial_byte_rx: RTL and testbench
=================================

# serial_byte_rx

Receives asynchronous serial frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit, idle high) from the registered 1-bit line produced by the upstream `d_flipflop` stage, and assembles them into parallel words. It sits directly downstream of that flip-flop, which provides the registered `rx_bit` input. It emits a one-cycle `data_valid` pulse per good frame and a one-cycle `frame_error` pulse per bad stop bit.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, >= 4.
- `DATA_BITS`, 8: data bits per frame; 5..9.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clock clk.
- `rx_bit`  in  1  registered serial line; idle level 1.
- `data_out`  out  DATA_BITS  last good word; holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse: `data_out` was updated this cycle.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE, START, DATA, STOP, WAIT_IDLE.
  - Single bit-timer counter, width $clog2(CLKS_PER_BIT), cleared on every state entry.
- IDLE:
  - `rx_bit`==0 -> START.
- START:
  - At the half-bit point, sample `rx_bit`.
  - 0 -> DATA.
  - 1 -> IDLE as a glitch, with no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, sample `rx_bit` into a shift register, LSB first.
  - After DATA_BITS samples -> STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles.
  - 1: load `data_out`, pulse `data_valid`, go to IDLE.
  - 0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_bit`==1, then -> IDLE.
  - This prevents a held-low break from generating repeated error frames.
- `data_valid` and `frame_error` are never asserted in the same cycle.
- Reset, including mid-frame:
  - State returns to IDLE, the shift register and `data_out` clear to 0, and all pulses and `busy` drop to 0.
  - A partial frame is discarded with no pulse.
- Reset values: `data_out`=0, `data_valid`=0, `frame_error`=0, `busy`=0.

## Timing
- N = CLKS_PER_BIT, B = DATA_BITS. Cycle 0 is the first cycle in which IDLE sees `rx_bit`==0.
- Sample points:
  - Start re-check at cycle N/2.
  - Data bit k (0-based) at cycle N/2 + (k+1)·N.
  - Stop bit at cycle N/2 + (B+1)·N.
- `busy` is high from cycle 1 through the stop-sample cycle inclusive.
- `data_valid` or `frame_error` is high in the cycle after the stop sample. `data_out` is valid in that same cycle, since all outputs are registered.
- That pulse cycle is already IDLE, so a start bit beginning in that cycle is detected. Back-to-back frames are received with no lost cycles.
- A glitch shorter than N/2 cycles returns to IDLE at cycle N/2 + 1.
- All outputs are registered. There is no combinational path from `rx_bit` to any output.

## Structure
- Package `serial_rx_pkg`:
  - State encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4; 3-bit).
  - Default `CLKS_PER_BIT`/`DATA_BITS` constants shared with a future transmitter.
- Sub-module `rx_bit_timer`:
  - Parameterised counter with `clear` input and `half_tick`/`full_tick` outputs.
  - Reused by the transmitter.
- The FSM, shift register and output registers live in `serial_byte_rx`.

## Test plan
All scenarios use N=16, B=8.
- Frame 0xA5 with stop 1 -> `data_valid` high only at cycle 153, `data_out`=0xA5, `busy` high cycles 1–152.
- 3-cycle low glitch on idle line -> no pulse; `busy` high cycles 1–8, low from cycle 9; `data_out` unchanged.
- Frame 0x3C with stop bit 0, then line held low 100 cycles, then high -> one `frame_error` at cycle 153, `data_out` keeps its prior value, and no further pulses while the line is low.
- Back-to-back frames 0x01, 0xFF with the second start bit at cycle 153 -> `data_valid` at cycles 153 and 306, `data_out` 0x01 then 0xFF.
- `reset` asserted at cycle 60 of a frame -> all outputs 0 immediately (asynchronous); after release, the next full frame 0x5A is received correctly.
- All-zero data 0x00 with valid stop -> `data_valid` with `data_out`=0x00 and no `frame_error`.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: state encoding and default
// line timing, kept here so a future transmitter can use the same constants.
package serial_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the mid-bit and
// end-of-bit cycles; clear restarts the count from zero on the next cycle.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_COUNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Explicit wrap keeps the period exact when CLKS_PER_BIT is not a power of two.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || (count_q == FULL_COUNT)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign half_tick = (count_q == HALF_COUNT);
  assign full_tick = (count_q == FULL_COUNT);

endmodule

// File: rtl/serial_byte_rx.sv
// Asynchronous serial frame receiver (start, LSB-first data, stop) producing
// a registered parallel word with one-cycle valid / framing-error pulses.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 busy_q, busy_d;
  logic                 timer_clear;
  logic                 half_tick;
  logic                 full_tick;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_bit) state_d = START;
      end
      START: begin
        if (half_tick) begin
          bit_cnt_d = '0;
          state_d   = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_bit) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must return high before another frame is accepted.
        if (rx_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    timer_clear = (state_d != state_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx at 16 clocks per bit and 8 data bits;
// cycle numbers are counted from the first low cycle of each frame.
module tb_serial_byte_rx;

  localparam int N = 16;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_bit = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;

  always #5 clk = ~clk;

  serial_byte_rx #(
    .CLKS_PER_BIT(N),
    .DATA_BITS   (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_bit     (rx_bit),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  // Line level at cycle c of a frame whose start bit begins at cycle 0.
  function automatic logic frame_line(input logic [7:0] d, input logic stop_bit, input int c);
    int idx;
    if (c < 0) return 1'b1;
    if (c < N) return 1'b0;
    if (c < (B + 1) * N) begin
      idx = (c - N) / N;
      return d[idx[2:0]];
    end
    if (c < (B + 2) * N) return stop_bit;
    return 1'b1;
  endfunction

  // Drive one cycle's line level just after the rising edge, then wait to mid-cycle.
  task automatic drive_cycle(input logic level);
    @(posedge clk);
    #1 rx_bit = level;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid); end
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    model_data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_a5;
    logic [7:0] exp_data;
    for (int c = 0; c < 176; c++) begin
      drive_cycle(frame_line(8'hA5, 1'b1, c));
      exp_data = (c >= 153) ? 8'hA5 : model_data;
      checks += 4;
      if (data_valid !== (c == 153)) begin errors++; $display("[TB] FAIL a5_valid cycle %0d: got %b expected %b", c, data_valid, (c == 153)); end
      if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL a5_frame_error cycle %0d: got %b expected 0", c, frame_error); end
      if (busy !== (c >= 1 && c <= 152)) begin errors++; $display("[TB] FAIL a5_busy cycle %0d: got %b expected %b", c, busy, (c >= 1 && c <= 152)); end
      if (data_out !== exp_data) begin errors++; $display("[TB] FAIL a5_data_out cycle %0d: got %h expected %h", c, data_out, exp_data); end
    end
    model_data = 8'hA5;
  endtask

  task automatic test_glitch;
    for (int c = 0; c < 40; c++) begin
      drive_cycle((c < 3) ? 1'b0 : 1'b1);
      checks += 4;
      if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid cycle %0d: got %b expected 0", c, data_valid); end
      if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL glitch_frame_error cycle %0d: got %b expected 0", c, frame_error); end
      if (busy !== (c >= 1 && c <= 8)) begin errors++; $display("[TB] FAIL glitch_busy cycle %0d: got %b expected %b", c, busy, (c >= 1 && c <= 8)); end
      if (data_out !== model_data) begin errors++; $display("[TB] FAIL glitch_data_out cycle %0d: got %h expected %h", c, data_out, model_data); end
    end
  endtask

  task automatic test_frame_error;
    logic level;
    for (int c = 0; c < 280; c++) begin
      if (c < 144) level = frame_line(8'h3C, 1'b0, c);
      else level = (c < 260) ? 1'b0 : 1'b1;
      drive_cycle(level);
      checks += 4;
      if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL ferr_valid cycle %0d: got %b expected 0", c, data_valid); end
      if (frame_error !== (c == 153)) begin errors++; $display("[TB] FAIL ferr_frame_error cycle %0d: got %b expected %b", c, frame_error, (c == 153)); end
      if (busy !== (c >= 1 && c <= 260)) begin errors++; $display("[TB] FAIL ferr_busy cycle %0d: got %b expected %b", c, busy, (c >= 1 && c <= 260)); end
      if (data_out !== model_data) begin errors++; $display("[TB] FAIL ferr_data_out cycle %0d: got %h expected %h", c, data_out, model_data); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       level;
    for (int c = 0; c < 330; c++) begin
      level = (c < 153) ? frame_line(8'h01, 1'b1, c) : frame_line(8'hFF, 1'b1, c - 153);
      drive_cycle(level);
      if (c >= 306) exp_data = 8'hFF;
      else if (c >= 153) exp_data = 8'h01;
      else exp_data = model_data;
      exp_busy = (c >= 1 && c <= 152) || (c >= 154 && c <= 305);
      checks += 4;
      if (data_valid !== (c == 153 || c == 306)) begin errors++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected %b", c, data_valid, (c == 153 || c == 306)); end
      if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL b2b_frame_error cycle %0d: got %b expected 0", c, frame_error); end
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL b2b_busy cycle %0d: got %b expected %b", c, busy, exp_busy); end
      if (data_out !== exp_data) begin errors++; $display("[TB] FAIL b2b_data_out cycle %0d: got %h expected %h", c, data_out, exp_data); end
    end
    model_data = 8'hFF;
  endtask

  task automatic test_mid_reset;
    logic [7:0] exp_data;
    for (int c = 0; c <= 60; c++) begin
      drive_cycle(frame_line(8'hC3, 1'b1, c));
      checks++;
      if (busy !== (c >= 1)) begin errors++; $display("[TB] FAIL mrst_busy_pre cycle %0d: got %b expected %b", c, busy, (c >= 1)); end
    end
    reset = 1'b1;
    #1;
    checks += 4;
    if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL mrst_data_out: got %h expected 00", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL mrst_data_valid: got %b expected 0", data_valid); end
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL mrst_frame_error: got %b expected 0", frame_error); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mrst_busy: got %b expected 0", busy); end
    rx_bit = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_data = 8'h00;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 176; c++) begin
      drive_cycle(frame_line(8'h5A, 1'b1, c));
      exp_data = (c >= 153) ? 8'h5A : model_data;
      checks += 4;
      if (data_valid !== (c == 153)) begin errors++; $display("[TB] FAIL mrst_5a_valid cycle %0d: got %b expected %b", c, data_valid, (c == 153)); end
      if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL mrst_5a_frame_error cycle %0d: got %b expected 0", c, frame_error); end
      if (busy !== (c >= 1 && c <= 152)) begin errors++; $display("[TB] FAIL mrst_5a_busy cycle %0d: got %b expected %b", c, busy, (c >= 1 && c <= 152)); end
      if (data_out !== exp_data) begin errors++; $display("[TB] FAIL mrst_5a_data_out cycle %0d: got %h expected %h", c, data_out, exp_data); end
    end
    model_data = 8'h5A;
  endtask

  task automatic test_zero_data;
    logic [7:0] exp_data;
    for (int c = 0; c < 176; c++) begin
      drive_cycle(frame_line(8'h00, 1'b1, c));
      exp_data = (c >= 153) ? 8'h00 : model_data;
      checks += 3;
      if (data_valid !== (c == 153)) begin errors++; $display("[TB] FAIL zero_valid cycle %0d: got %b expected %b", c, data_valid, (c == 153)); end
      if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL zero_frame_error cycle %0d: got %b expected 0", c, frame_error); end
      if (data_out !== exp_data) begin errors++; $display("[TB] FAIL zero_data_out cycle %0d: got %h expected %h", c, data_out, exp_data); end
    end
    model_data = 8'h00;
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_mid_reset();
    test_zero_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
